// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between two byte-stream requesters. One
// requester owns the transmitter for a whole frame, which ends with a byte
// that has `last` set. The grant is released when that last byte has been
// taken by the transmitter, or when the owner stalls mid-frame for too long.
// Ties are broken round-robin.
//
// Parameters:
//   TIMEOUT_CYC  number of stalled cycles before an owner loses its grant
//                (0 disables the timeout)
//
// Ports:
//   i_clk, i_rst                       clock, asynchronous active-high reset
//   i_reqN_data/valid/last, o_reqN_ready
//                                      requester N byte stream (N = 0, 1);
//                                      a byte moves when valid && ready
//   o_tx_data, o_tx_valid, i_tx_ready  byte stream into uart_tx
//   o_grant                            one-hot owner, 00 = no owner
//   o_abort                            one-cycle pulse on timeout revocation
//
// o_reqN_ready is combinational. All other outputs come straight from
// registers.
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_req0_data,
  input  logic       i_req0_valid,
  input  logic       i_req0_last,
  output logic       o_req0_ready,
  input  logic [7:0] i_req1_data,
  input  logic       i_req1_valid,
  input  logic       i_req1_last,
  output logic       o_req1_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic [1:0] o_grant,
  output logic       o_abort
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // The counter holds k in the k-th stalled cycle (counting from 0). The
  // terminal cycle is the one whose stall would bring the count to
  // TIMEOUT_CYC.
  localparam logic [CNT_W-1:0] CNT_TERM = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1)
                                                            : {CNT_W{1'b0}};
  localparam logic TMO_EN = (TIMEOUT_CYC > 0);

  logic [1:0]       state_r, state_s;
  logic [1:0]       grant_r, grant_s;
  logic [7:0]       tx_data_r, tx_data_s;
  logic             tx_valid_r, tx_valid_s;
  logic             abort_r, abort_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  // rr_r = 1 means requester 1 wins the next tie.
  logic             rr_r, rr_s;

  logic             own_valid_s;
  logic             own_last_s;
  logic [7:0]       own_data_s;
  logic             xfer_s;
  logic             tx_done_s;
  logic             stall_s;
  logic             timeout_s;

  // Mux the current owner's stream and derive the handshake/stall events.
  always_comb begin
    own_valid_s = 1'b0;
    own_last_s  = 1'b0;
    own_data_s  = 8'h00;
    if (grant_r[0]) begin
      own_valid_s = i_req0_valid;
      own_last_s  = i_req0_last;
      own_data_s  = i_req0_data;
    end else if (grant_r[1]) begin
      own_valid_s = i_req1_valid;
      own_last_s  = i_req1_last;
      own_data_s  = i_req1_data;
    end else begin
      own_valid_s = 1'b0;
      own_last_s  = 1'b0;
      own_data_s  = 8'h00;
    end
    o_req0_ready = (state_r == ST_OWN) && grant_r[0] && !tx_valid_r;
    o_req1_ready = (state_r == ST_OWN) && grant_r[1] && !tx_valid_r;
    xfer_s       = (state_r == ST_OWN) && own_valid_s && !tx_valid_r;
    tx_done_s    = tx_valid_r && i_tx_ready;
    // Waiting on the transmitter (tx_valid_r high) is never a stall.
    stall_s      = (state_r == ST_OWN) && !tx_valid_r && !own_valid_s;
    timeout_s    = TMO_EN && stall_s && (cnt_r == CNT_TERM);
  end

  // Next-state logic for the arbiter FSM, output buffer and timeout counter.
  always_comb begin
    state_s    = state_r;
    grant_s    = grant_r;
    rr_s       = rr_r;
    cnt_s      = cnt_r;
    abort_s    = 1'b0;
    tx_data_s  = tx_data_r;
    if (tx_done_s) begin
      tx_valid_s = 1'b0;
    end else begin
      tx_valid_s = tx_valid_r;
    end

    case (state_r)
      ST_IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        if (i_req0_valid && i_req1_valid) begin
          grant_s = rr_r ? 2'b10 : 2'b01;
          state_s = ST_OWN;
        end else if (i_req0_valid) begin
          grant_s = 2'b01;
          state_s = ST_OWN;
        end else if (i_req1_valid) begin
          grant_s = 2'b10;
          state_s = ST_OWN;
        end else begin
          grant_s = 2'b00;
          state_s = ST_IDLE;
        end
      end

      ST_OWN: begin
        if (xfer_s) begin
          // An owner byte always wins, even in the terminal timeout cycle.
          tx_data_s  = own_data_s;
          tx_valid_s = 1'b1;
          cnt_s      = {CNT_W{1'b0}};
          if (own_last_s) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_OWN;
          end
        end else if (timeout_s) begin
          abort_s = 1'b1;
          grant_s = 2'b00;
          state_s = ST_IDLE;
          rr_s    = grant_r[0];
          cnt_s   = {CNT_W{1'b0}};
        end else if (stall_s) begin
          cnt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_s = cnt_r;
        end
      end

      ST_DRAIN: begin
        cnt_s = {CNT_W{1'b0}};
        if (tx_done_s) begin
          state_s = ST_IDLE;
          grant_s = 2'b00;
          // Point the next tie away from the requester that just finished.
          rr_s    = grant_r[0];
        end else begin
          state_s = ST_DRAIN;
        end
      end

      default: begin
        state_s    = ST_IDLE;
        grant_s    = 2'b00;
        tx_valid_s = 1'b0;
        cnt_s      = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers; reset drops any buffered byte and the grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r    <= ST_IDLE;
      grant_r    <= 2'b00;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      abort_r    <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      rr_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      grant_r    <= grant_s;
      tx_data_r  <= tx_data_s;
      tx_valid_r <= tx_valid_s;
      abort_r    <= abort_s;
      cnt_r      <= cnt_s;
      rr_r       <= rr_s;
    end
  end

  assign o_tx_data  = tx_data_r;
  assign o_tx_valid = tx_valid_r;
  assign o_grant    = grant_r;
  assign o_abort    = abort_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Self-checking bench for uart_tx_arbiter (TIMEOUT_CYC = 8). Expected bytes
// are queued in the order the transmitter must see them. A negedge monitor
// pops the queue on every transmitter acceptance and compares the byte.
// Grant, ready, abort and reset behaviour are checked against cycle
// positions derived from the stimulus.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req0_data = 8'h00;
  logic       req0_valid = 1'b0;
  logic       req0_last = 1'b0;
  logic       req0_ready;
  logic [7:0] req1_data = 8'h00;
  logic       req1_valid = 1'b0;
  logic       req1_last = 1'b0;
  logic       req1_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [1:0] grant;
  logic       abort;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int abort_total = 0;
  int r1_hi = 0;
  logic [7:0] sb[$];

  uart_tx_arbiter #(.TIMEOUT_CYC(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0_data  (req0_data),
    .i_req0_valid (req0_valid),
    .i_req0_last  (req0_last),
    .o_req0_ready (req0_ready),
    .i_req1_data  (req1_data),
    .i_req1_valid (req1_valid),
    .i_req1_last  (req1_last),
    .o_req1_ready (req1_ready),
    .o_tx_data    (tx_data),
    .o_tx_valid   (tx_valid),
    .i_tx_ready   (tx_ready),
    .o_grant      (grant),
    .o_abort      (abort)
  );

  always #5 clk = ~clk;

  // Cycle index: at a negedge, cyc names the cycle being sampled.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: a byte leaves on each valid && ready at the next edge.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        check_value("tx_unexpected", {24'h0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        check_value("tx_byte", {24'h0, tx_data}, {24'h0, sb.pop_front()});
      end
    end
    if (abort) abort_total++;
    if (req1_ready) r1_hi++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until accepted; acc = cycle of the handshake.
  task automatic send_byte(input int r, input logic [7:0] d, input logic l, output int acc);
    logic got;
    got = 1'b0;
    acc = -1;
    if (r == 0) begin
      req0_data = d; req0_last = l; req0_valid = 1'b1;
    end else begin
      req1_data = d; req1_last = l; req1_valid = 1'b1;
    end
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if ((r == 0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        acc = cyc;
      end
      step();
    end
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
    if (!got) check_value("send_bound", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_grant"}, {30'h0, grant}, 32'h0);
    check_value({tag, "_txv"},   {31'h0, tx_valid}, 32'h0);
    check_value({tag, "_txd"},   {24'h0, tx_data}, 32'h0);
    check_value({tag, "_abort"}, {31'h0, abort}, 32'h0);
    check_value({tag, "_rdy"},   {30'h0, req1_ready, req0_ready}, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    step();
    rst = 1'b0;
  endtask

  initial begin
    int a0, a1, a3, acc1, first_abort, win_aborts, bad, base_abort, base_r1;
    logic took;

    // ---------------- single frame ----------------
    do_reset();
    base_r1 = r1_hi;
    sb.push_back(8'h55); sb.push_back(8'hA3); sb.push_back(8'h0F);
    req0_data = 8'h55; req0_last = 1'b0; req0_valid = 1'b1;
    @(negedge clk);
    check_value("grant_lat_t", {30'h0, grant}, 32'h0);
    step();
    @(negedge clk);
    check_value("grant_lat_t1", {30'h0, grant}, 32'h1);
    check_value("ready0_lat_t1", {31'h0, req0_ready}, 32'h1);
    step();
    req0_valid = 1'b0;
    send_byte(0, 8'hA3, 1'b0, a0);
    send_byte(0, 8'h0F, 1'b1, a0);
    @(negedge clk);
    check_value("grant_drain", {30'h0, grant}, 32'h1);
    step();
    @(negedge clk);
    check_value("grant_release", {30'h0, grant}, 32'h0);
    check_value("ready1_never", r1_hi - base_r1, 32'd0);
    step();

    // ---------------- tie arbitration (twice) ----------------
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      sb.push_back(8'h11); sb.push_back(8'h22);
      fork
        send_byte(0, 8'h11, 1'b1, a0);
        send_byte(1, 8'h22, 1'b1, a1);
      join
      check_value("tie_order", (a0 < a1) ? 32'd1 : 32'd0, 32'd1);
    end

    // ---------------- frame lock ----------------
    sb.push_back(8'hA1); sb.push_back(8'hA2); sb.push_back(8'hA3); sb.push_back(8'h77);
    fork
      begin
        send_byte(0, 8'hA1, 1'b0, a3);
        send_byte(0, 8'hA2, 1'b0, a3);
        send_byte(0, 8'hA3, 1'b1, a3);
      end
      send_byte(1, 8'h77, 1'b1, a1);
    join
    // Transmitter takes A3 at a3+1, IDLE at a3+2, req1 granted at a3+3.
    check_value("lock_grant1", a1, a3 + 3);
    repeat (3) step();

    // ---------------- backpressure ----------------
    base_abort = abort_total;
    tx_ready = 1'b0;
    sb.push_back(8'hB1); sb.push_back(8'hB2);
    send_byte(0, 8'hB1, 1'b0, a0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!tx_valid || tx_data != 8'hB1 || req0_ready || grant != 2'b01) bad++;
      step();
    end
    check_value("bp_hold", bad, 32'd0);
    tx_ready = 1'b1;
    send_byte(0, 8'hB2, 1'b1, a0);
    repeat (4) step();
    check_value("bp_no_abort", abort_total - base_abort, 32'd0);

    // ---------------- timeout ----------------
    sb.push_back(8'hC1); sb.push_back(8'hD1);
    send_byte(0, 8'hC1, 1'b0, a0);
    req1_data = 8'hD1; req1_last = 1'b1; req1_valid = 1'b1;
    first_abort = -1; win_aborts = 0; acc1 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      took = req1_valid && req1_ready;
      if (abort) begin
        win_aborts++;
        if (first_abort < 0) first_abort = cyc;
      end
      if (took) acc1 = cyc;
      step();
      if (took) req1_valid = 1'b0;
    end
    req1_valid = 1'b0;
    // Buffer empties at a0+2; abort 8 cycles later.
    check_value("tmo_abort_count", win_aborts, 32'd1);
    check_value("tmo_abort_cycle", first_abort, a0 + 10);
    check_value("tmo_req1_grant", acc1, a0 + 11);

    // Owner valid arriving in the terminal cycle wins, no abort.
    base_abort = abort_total;
    sb.push_back(8'hE1); sb.push_back(8'hE2);
    send_byte(0, 8'hE1, 1'b0, a0);
    repeat (8) step();
    send_byte(0, 8'hE2, 1'b1, a1);
    check_value("term_accept", a1, a0 + 9);
    repeat (12) step();
    check_value("term_no_abort", abort_total - base_abort, 32'd0);

    // ---------------- reset mid-frame ----------------
    tx_ready = 1'b0;
    send_byte(0, 8'hF1, 1'b0, a0);
    @(negedge clk);
    check_value("pre_rst_txv", {31'h0, tx_valid}, 32'h1);
    step();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    step();
    rst = 1'b0;
    tx_ready = 1'b1;
    sb.push_back(8'h31); sb.push_back(8'h32);
    fork
      send_byte(0, 8'h31, 1'b1, a0);
      send_byte(1, 8'h32, 1'b1, a1);
    join
    check_value("post_rst_tie", (a0 < a1) ? 32'd1 : 32'd0, 32'd1);
    repeat (4) step();
    check_value("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
